rep_tx_encoder: RTL and testbench

Serial repetition-code transmitter. It accepts a parallel data word over a valid/ready handshake and shifts it out LSB-first, one bit per clock. Each data bit is repeated REP consecutive times so that a downstream streaming majority voter can recover it. An optional per-word error-injection flag corrupts one copy of every bit, so the voter's single-error correction can be exercised in-system.

---
 rtl/rep_tx_encoder.sv | 134 +++++++++++++
 tb/tb_rep_tx_encoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rep_tx_encoder.sv
// -----------------------------------------------------------------------------
// rep_tx_encoder
//   Serial repetition-code transmitter. A DATA_W-bit word accepted over a
//   valid/ready handshake is shifted out LSB-first. Each data bit is repeated
//   REP consecutive cycles so that a downstream majority voter can recover it.
//   When the word's in_inj flag is set, the first copy of every bit is inverted.
//   This exercises the voter's single-error correction.
//
// Parameters
//   DATA_W  data word width (>= 1)
//   REP     repetitions per data bit (odd, >= 1)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   word offered
//   in_data    word to transmit
//   in_inj     inject errors into this word (sampled with in_data)
//   in_ready   block can accept a word this cycle (combinational)
//   out_bit    serial coded bit
//   out_valid  out_bit is meaningful
//   out_first  first coded bit of a word
//   out_last   final coded bit of a word
//   busy       a word is being transmitted
// -----------------------------------------------------------------------------
module rep_tx_encoder #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inj,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] sreg_q,    sreg_d;
  logic              inj_q,     inj_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [RW-1:0]     rep_idx_q, rep_idx_d;

  logic sending;
  logic word_end;
  logic accept;

  // Output decode uses only registered state, so there is no in_* -> out_* path.
  assign sending  = (state_q == SEND);
  assign word_end = sending && (bit_idx_q == BIT_LAST) && (rep_idx_q == REP_LAST);

  // Ready on the final coded bit as well, which lets words run back to back
  // with no idle cycle between them.
  assign in_ready = !sending || word_end;
  assign accept   = in_valid && in_ready;

  assign out_valid = sending;
  assign busy      = sending;
  assign out_first = sending && (bit_idx_q == '0) && (rep_idx_q == '0);
  assign out_last  = word_end;
  // Only copy 0 of each bit is corrupted, so a majority of REP >= 3 still wins.
  // With REP == 1 every bit is inverted.
  assign out_bit   = sending && (sreg_q[0] ^ (inj_q && (rep_idx_q == '0)));

  // NOTE: every next-state signal gets a default first, so no path through
  //       this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    inj_d     = inj_q;
    bit_idx_d = bit_idx_q;
    rep_idx_d = rep_idx_q;

    if (sending) begin
      if (rep_idx_q != REP_LAST) begin
        rep_idx_d = rep_idx_q + REP_ONE;
      end else begin
        rep_idx_d = '0;
        sreg_d    = sreg_q >> 1;
        bit_idx_d = bit_idx_q + BIT_ONE;
      end
      if (word_end) begin
        state_d   = IDLE;
        bit_idx_d = '0;
      end
    end

    // Accepting a word overrides the advance, including on the word_end cycle.
    if (accept) begin
      state_d   = SEND;
      sreg_d    = in_data;
      inj_d     = in_inj;
      bit_idx_d = '0;
      rep_idx_d = '0;
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the values
  //       computed before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      inj_q     <= 1'b0;
      bit_idx_q <= '0;
      rep_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      inj_q     <= inj_d;
      bit_idx_q <= bit_idx_d;
      rep_idx_q <= rep_idx_d;
    end
  end

endmodule

// File: tb/tb_rep_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_rep_tx_encoder
//   Directed bench for rep_tx_encoder. The main instance uses the default
//   DATA_W=8 and REP=3. A second instance uses DATA_W=1 and REP=1 for the
//   degenerate corner. Expected streams are hand-computed constants. Bit i of
//   each constant corresponds to coded bit i, which appears in cycle i+1 after
//   the accepting edge.
// -----------------------------------------------------------------------------
module tb_rep_tx_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_inj;
  logic       in_ready, out_bit, out_valid, out_first, out_last, busy;

  logic       c_in_valid;
  logic [0:0] c_in_data;
  logic       c_in_inj;
  logic       c_in_ready, c_out_bit, c_out_valid, c_out_first, c_out_last, c_busy;

  int n_vec  = 0;
  int n_miss = 0;

  // One bit per cycle of the most recent run() call.
  logic [63:0] cap_bit, cap_valid, cap_first, cap_last, cap_ready, cap_busy;

  always #5 clk = ~clk;

  rep_tx_encoder #(.DATA_W(8), .REP(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_inj    (in_inj),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  rep_tx_encoder #(.DATA_W(1), .REP(1)) dut_c (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (c_in_valid),
    .in_data   (c_in_data),
    .in_inj    (c_in_inj),
    .in_ready  (c_in_ready),
    .out_bit   (c_out_bit),
    .out_valid (c_out_valid),
    .out_first (c_out_first),
    .out_last  (c_out_last),
    .busy      (c_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs n cycles from the current point, which is just after a rising edge.
  // In cycle i, in_valid is vmask[i] and rst is rmask[i]. in_data is d0 before
  // cycle sw and d1 from cycle sw on. Outputs are sampled on the falling edge.
  task automatic run(input int n, input logic [63:0] vmask, input logic [7:0] d0,
                     input logic [7:0] d1, input int sw, input logic inj,
                     input logic [63:0] rmask);
    cap_bit = '0; cap_valid = '0; cap_first = '0;
    cap_last = '0; cap_ready = '0; cap_busy = '0;
    for (int i = 0; i < n; i++) begin
      in_valid = vmask[i];
      in_data  = (i < sw) ? d0 : d1;
      in_inj   = inj;
      rst      = rmask[i];
      @(negedge clk);
      cap_bit[i]   = out_bit;
      cap_valid[i] = out_valid;
      cap_first[i] = out_first;
      cap_last[i]  = out_last;
      cap_ready[i] = in_ready;
      cap_busy[i]  = busy;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  logic [7:0] voted;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_inj     = 1'b0;
    c_in_valid = 1'b0;
    c_in_data  = '0;
    c_in_inj   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bit",   64'(out_bit),   64'd0);
    check("rst_out_first", 64'(out_first), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    @(posedge clk);
    #1;

    // Single word 0xA5, stream 111 000 111 000 000 111 000 111.
    run(27, 64'h1, 8'hA5, 8'hA5, 99, 1'b0, 64'h0);
    check("a_ready_idle", 64'(cap_ready[0]),      64'd1);
    check("a_valid",      64'(cap_valid[26:0]),   64'h1FF_FFFE);
    check("a_busy",       64'(cap_busy[26:0]),    64'h1FF_FFFE);
    check("a_stream",     64'(cap_bit[24:1]),     64'hE3_81C7);
    check("a_first",      64'(cap_first[26:0]),   64'h2);
    check("a_last",       64'(cap_last[26:0]),    64'h100_0000);
    check("a_ready",      64'(cap_ready[26:0]),   64'h700_0001);

    // Back-to-back words 0xA5 then 0x3C, with in_valid held until the second accept.
    run(51, 64'h1FF_FFFF, 8'hA5, 8'h3C, 1, 1'b0, 64'h0);
    check("b_valid",   64'(cap_valid[50:0]),  64'h1_FFFF_FFFF_FFFE);
    check("b_stream0", 64'(cap_bit[24:1]),    64'hE3_81C7);
    check("b_stream1", 64'(cap_bit[48:25]),   64'h03_FFC0);
    check("b_first",   64'(cap_first[50:0]),  64'h2_0000_02);
    check("b_last",    64'(cap_last[50:0]),   64'h1_0000_0100_0000);
    check("b_ready",   64'(cap_ready[50:0]),  64'h7_0000_0100_0001);

    // Injection on 0x01: bit 0 -> 0,1,1 and bits 1..7 -> 1,0,0.
    run(26, 64'h1, 8'h01, 8'h01, 99, 1'b1, 64'h0);
    check("c_valid",  64'(cap_valid[25:0]), 64'h1FF_FFFE);
    check("c_stream", 64'(cap_bit[24:1]),   64'h24_924E);
    voted = '0;
    for (int b = 0; b < 8; b++) begin
      voted[b] = (32'(cap_bit[1+3*b]) + 32'(cap_bit[2+3*b]) + 32'(cap_bit[3+3*b])) >= 32'd2;
    end
    check("c_voted", 64'(voted), 64'h01);

    // Busy ignore: 0x00 is in flight while 0xFF is offered in cycles 5..20.
    run(27, 64'h1F_FFE1, 8'h00, 8'hFF, 5, 1'b0, 64'h0);
    check("d_stream",   64'(cap_bit[26:0]),   64'h0);
    check("d_valid",    64'(cap_valid[26:0]), 64'h1FF_FFFE);
    check("d_ready",    64'(cap_ready[20:5]), 64'h0);
    check("d_first",    64'(cap_first[26:0]), 64'h2);

    // Reset during cycle 10 of 0xA5, then offer 0x0F in cycle 12.
    run(39, 64'h1001, 8'hA5, 8'h0F, 11, 1'b0, 64'h400);
    check("e_stream_pre", 64'(cap_bit[10:1]),    64'h1C7);
    check("e_valid",      64'(cap_valid[38:0]),  64'h1F_FFFF_E7FE);
    check("e_ready_gap",  64'(cap_ready[12:11]), 64'h3);
    check("e_stream_new", 64'(cap_bit[36:13]),   64'h00_0FFF);
    check("e_first",      64'(cap_first[38:0]),  64'h2002);
    check("e_last",       64'(cap_last[38:0]),   64'h10_0000_0000);

    // Corner case DATA_W=1, REP=1: word 1 and then an injected word 1, back to back.
    c_in_valid = 1'b1;
    c_in_data  = 1'b1;
    c_in_inj   = 1'b0;
    @(negedge clk);
    check("f_idle_ready", 64'(c_in_ready),  64'd1);
    check("f_idle_valid", 64'(c_out_valid), 64'd0);
    @(posedge clk);
    #1;
    c_in_inj = 1'b1;
    @(negedge clk);
    check("f_w0_flags", 64'({c_out_valid, c_out_first, c_out_last, c_busy, c_in_ready}), 64'h1F);
    check("f_w0_bit",   64'(c_out_bit), 64'd1);
    @(posedge clk);
    #1;
    c_in_valid = 1'b0;
    @(negedge clk);
    check("f_w1_flags", 64'({c_out_valid, c_out_first, c_out_last}), 64'h7);
    check("f_w1_bit",   64'(c_out_bit), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("f_end_valid", 64'(c_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
